fetch_stage: RTL

Instruction-fetch stage with IF/ID pipeline register; sits directly upstream of the control unit and feeds it the opcode field.
- Holds the PC and issues word fetches to instruction memory over a req/ack handshake.
- Registers the returned instruction and PC+4 for decode.
- Handles stall from decode/hazard logic and redirects from taken branch (EX) or jump (ID).

---
 rtl/cpu_pkg.sv | 24 ++
 rtl/pc_next_sel.sv | 31 +++
 rtl/fetch_stage.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared types and constants for the CPU front end: fetch FSM states,
// well-known opcodes and instruction field positions.
package cpu_pkg;

    typedef enum logic [1:0] {
        BOOT,
        FETCH,
        HOLD
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
    localparam logic [5:0]  OPC_J     = 6'b000010;
    localparam logic [5:0]  OPC_BEQ   = 6'b000100;

    localparam int unsigned OPC_MSB = 31;
    localparam int unsigned OPC_LSB = 26;
    localparam int unsigned IDX_MSB = 25;
    localparam int unsigned IDX_LSB = 0;

    function automatic logic [5:0] opcode_of(input logic [31:0] instr);
        return instr[OPC_MSB:OPC_LSB];
    endfunction

endpackage

// File: rtl/pc_next_sel.sv
// Combinational next-PC selection: sequential PC+4 and the redirect target,
// with a taken branch winning over a jump decoded in the same cycle.
module pc_next_sel
    import cpu_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
) (
    input  logic [ADDR_W-1:0]      pc,
    input  logic                   branch_taken,
    input  logic [ADDR_W-1:0]      branch_target,
    input  logic                   jump,
    input  logic [IDX_MSB:IDX_LSB] jump_index,
    input  logic [ADDR_W-1:0]      id_pc_plus4,
    output logic [ADDR_W-1:0]      pc_plus4,
    output logic                   redirect,
    output logic [ADDR_W-1:0]      redirect_target
);

    always_comb begin
        pc_plus4        = pc + ADDR_W'(4);
        redirect        = branch_taken | jump;
        redirect_target = pc_plus4;
        if (branch_taken) begin
            redirect_target = branch_target & ~ADDR_W'(3);
        end else if (jump) begin
            // Jump keeps the 256 MB region of the instruction after the J.
            redirect_target = (id_pc_plus4 & 32'hF000_0000) | {4'b0000, jump_index, 2'b00};
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, req/ack fetch handshake, one-entry skid for
// words returned under stall, and the IF/ID pipeline register.
module fetch_stage
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned ADDR_W   = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    input  logic              stall,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              jump,
    input  logic [25:0]       jump_index,
    output logic [ADDR_W-1:0] pc,
    output logic              id_valid,
    output logic [31:0]       id_instr,
    output logic [ADDR_W-1:0] id_pc_plus4,
    output logic [5:0]        id_opcode
);

    fetch_state_t      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              id_valid_q, id_valid_d;
    logic [31:0]       id_instr_q, id_instr_d;
    logic [ADDR_W-1:0] id_pc_plus4_q, id_pc_plus4_d;
    logic [31:0]       skid_q, skid_d;
    logic              redir_pend_q, redir_pend_d;
    logic [ADDR_W-1:0] redir_tgt_q, redir_tgt_d;

    logic [ADDR_W-1:0] pc_plus4;
    logic              redirect;
    logic [ADDR_W-1:0] redirect_target;

    pc_next_sel #(
        .ADDR_W(ADDR_W)
    ) u_pc_next_sel (
        .pc             (pc_q),
        .branch_taken   (branch_taken),
        .branch_target  (branch_target),
        .jump           (jump),
        .jump_index     (jump_index),
        .id_pc_plus4    (id_pc_plus4_q),
        .pc_plus4       (pc_plus4),
        .redirect       (redirect),
        .redirect_target(redirect_target)
    );

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        id_valid_d    = id_valid_q;
        id_instr_d    = id_instr_q;
        id_pc_plus4_d = id_pc_plus4_q;
        skid_d        = skid_q;
        redir_pend_d  = redir_pend_q;
        redir_tgt_d   = redir_tgt_q;

        unique case (state_q)
            BOOT: begin
                state_d = FETCH;
                if (redirect) begin
                    pc_d       = redirect_target;
                    id_valid_d = 1'b0;
                end
            end
            FETCH: begin
                if (imem_ack) begin
                    if (redirect) begin
                        pc_d         = redirect_target;
                        id_valid_d   = 1'b0;
                        redir_pend_d = 1'b0;
                    end else if (redir_pend_q) begin
                        pc_d         = redir_tgt_q;
                        id_valid_d   = 1'b0;
                        redir_pend_d = 1'b0;
                    end else if (stall) begin
                        skid_d  = imem_rdata;
                        pc_d    = pc_plus4;
                        state_d = HOLD;
                    end else begin
                        id_instr_d    = imem_rdata;
                        id_pc_plus4_d = pc_plus4;
                        id_valid_d    = 1'b1;
                        pc_d          = pc_plus4;
                    end
                end else if (redirect) begin
                    // Address must stay put until the in-flight word returns.
                    redir_tgt_d  = redirect_target;
                    redir_pend_d = 1'b1;
                    id_valid_d   = 1'b0;
                end else if (!stall) begin
                    id_valid_d = 1'b0;
                end
            end
            HOLD: begin
                if (redirect) begin
                    pc_d       = redirect_target;
                    id_valid_d = 1'b0;
                    state_d    = FETCH;
                end else if (!stall) begin
                    // pc already advanced past the skid word, so it is that word's PC+4.
                    id_instr_d    = skid_q;
                    id_pc_plus4_d = pc_q;
                    id_valid_d    = 1'b1;
                    state_d       = FETCH;
                end
            end
            default: state_d = BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= BOOT;
            pc_q          <= RESET_PC;
            id_valid_q    <= 1'b0;
            id_instr_q    <= NOP_INSTR;
            id_pc_plus4_q <= '0;
            skid_q        <= '0;
            redir_pend_q  <= 1'b0;
            redir_tgt_q   <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            id_valid_q    <= id_valid_d;
            id_instr_q    <= id_instr_d;
            id_pc_plus4_q <= id_pc_plus4_d;
            skid_q        <= skid_d;
            redir_pend_q  <= redir_pend_d;
            redir_tgt_q   <= redir_tgt_d;
        end
    end

    assign imem_req    = (state_q == FETCH);
    assign imem_addr   = pc_q;
    assign pc          = pc_q;
    assign id_valid    = id_valid_q;
    assign id_instr    = id_instr_q;
    assign id_pc_plus4 = id_pc_plus4_q;
    assign id_opcode   = opcode_of(id_instr_q);

endmodule
